wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_timeout.sv | 37 +++
 rtl/wb_arbiter2.sv | 166 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts enabled cycles, flags expiry for one cycle and restarts.
module wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] count_q, count_d;

    assign expired = (TIMEOUT_CYCLES != 0) && (count_q == Limit);

    always_comb begin
        count_d = count_q;
        // A zero limit disables the watchdog, so the counter is held at zero.
        if (TIMEOUT_CYCLES == 0 || clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (m0 = data, m1 = instruction) onto one slave.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed m0 priority.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dat_w,
    input  logic [3:0]  m0_sel,
    input  logic        m0_we,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic [2:0]  m0_cti,
    input  logic [1:0]  m0_bte,
    output logic [31:0] m0_dat_r,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dat_w,
    input  logic [3:0]  m1_sel,
    input  logic        m1_we,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic [2:0]  m1_cti,
    input  logic [1:0]  m1_bte,
    output logic [31:0] m1_dat_r,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_dat_w,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic        s_cyc,
    output logic        s_stb,
    output logic [2:0]  s_cti,
    output logic [1:0]  s_bte,
    input  logic [31:0] s_dat_r,
    input  logic        s_ack,
    input  logic        s_err
);

    import wb_arb_pkg::*;

    arb_state_t state_q, state_d;
    logic       gnt_stb;
    logic       tmo_expired;
    logic       tmo_err;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_d = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (m0_cyc && m1_cyc) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    state_d = last_q ? StGrant0 : StGrant1;
`else
                    state_d = StGrant0;
`endif
                end else if (m0_cyc) begin
                    state_d = StGrant0;
                end else if (m1_cyc) begin
                    state_d = StGrant1;
                end
`ifdef WB_ARB_ROUND_ROBIN_EN
                if (state_d == StGrant0) begin
                    last_d = 1'b0;
                end else if (state_d == StGrant1) begin
                    last_d = 1'b1;
                end
`endif
            end
            StGrant0: if (!m0_cyc) state_d = StIdle;
            StGrant1: if (!m1_cyc) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Strobe is only meaningful inside an active cycle of the owning master.
    assign gnt_stb = (state_q == StGrant0) ? (m0_cyc & m0_stb) :
                     (state_q == StGrant1) ? (m1_cyc & m1_stb) : 1'b0;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (gnt_stb & ~s_ack & ~s_err),
        .clear  (~gnt_stb | s_ack | s_err),
        .expired(tmo_expired)
    );

    // A real ack in the expiry cycle completes the transfer instead of erroring it.
    assign tmo_err = tmo_expired & gnt_stb & ~s_ack;

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    always_comb begin
        s_addr  = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_cti   = '0;
        s_bte   = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        unique case (state_q)
            StGrant0: begin
                s_addr  = m0_addr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_cyc   = m0_cyc;
                s_stb   = gnt_stb;
                s_cti   = m0_cti;
                s_bte   = m0_bte;
                m0_ack  = s_ack;
                m0_err  = s_err | tmo_err;
            end
            StGrant1: begin
                s_addr  = m1_addr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc;
                s_stb   = gnt_stb;
                s_cti   = m1_cti;
                s_bte   = m1_bte;
                m1_ack  = s_ack;
                m1_err  = s_err | tmo_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a 4-cycle timeout; honours WB_ARB_ROUND_ROBIN_EN.
module tb_wb_arbiter2;

    import wb_arb_pkg::*;

    logic        clk, rst;
    logic [31:0] m0_addr, m0_dat_w, m0_dat_r;
    logic [3:0]  m0_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic [2:0]  m0_cti;
    logic [1:0]  m0_bte;
    logic [31:0] m1_addr, m1_dat_w, m1_dat_r;
    logic [3:0]  m1_sel;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [2:0]  m1_cti;
    logic [1:0]  m1_bte;
    logic [31:0] s_addr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;

    int checks   = 0;
    int failures = 0;

    logic [31:0] beat_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [2:0]  beat_cti  [4] = '{CtiIncr, CtiIncr, CtiIncr, CtiEnd};
    logic [31:0] tie2_addr;

    wb_arbiter2 #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_addr (m0_addr),
        .m0_dat_w(m0_dat_w),
        .m0_sel  (m0_sel),
        .m0_we   (m0_we),
        .m0_cyc  (m0_cyc),
        .m0_stb  (m0_stb),
        .m0_cti  (m0_cti),
        .m0_bte  (m0_bte),
        .m0_dat_r(m0_dat_r),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_addr (m1_addr),
        .m1_dat_w(m1_dat_w),
        .m1_sel  (m1_sel),
        .m1_we   (m1_we),
        .m1_cyc  (m1_cyc),
        .m1_stb  (m1_stb),
        .m1_cti  (m1_cti),
        .m1_bte  (m1_bte),
        .m1_dat_r(m1_dat_r),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .s_addr  (s_addr),
        .s_dat_w (s_dat_w),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_cti   (s_cti),
        .s_bte   (s_bte),
        .s_dat_r (s_dat_r),
        .s_ack   (s_ack),
        .s_err   (s_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = '0; m0_dat_w = '0; m0_sel = '0; m0_we = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = CtiClassic; m0_bte = '0;
        m1_addr = '0; m1_dat_w = '0; m1_sel = '0; m1_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = CtiClassic; m1_bte = '0;
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;

        // Reset: nothing granted, slave responses must not leak to masters.
        #7;
        s_ack = 1'b1; s_err = 1'b1;
        settle();
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_err", m0_err, 0);
        chk("rst_m1_err", m1_err, 0);
        s_ack = 1'b0; s_err = 1'b0;
        rst = 1'b0;

        // Single m1 read: one-cycle grant latency and response routing.
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h8000_0000; m1_sel = 4'hF;
        settle();
        chk("lat_idle_s_cyc", s_cyc, 0);
        tick();
        settle();
        chk("g1_s_cyc", s_cyc, 1);
        chk("g1_s_stb", s_stb, 1);
        chk("g1_s_addr", s_addr, 32'h8000_0000);
        chk("g1_s_sel", s_sel, 4'hF);
        chk("g1_s_we", s_we, 0);
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        settle();
        chk("g1_m1_ack", m1_ack, 1);
        chk("g1_m0_ack", m0_ack, 0);
        chk("g1_m0_dat_r", m0_dat_r, 32'hDEAD_BEEF);
        chk("g1_m1_dat_r", m1_dat_r, 32'hDEAD_BEEF);
        tick();
        s_ack = 1'b0; s_err = 1'b1;
        settle();
        chk("g1_m1_err", m1_err, 1);
        chk("g1_m0_err", m0_err, 0);
        tick();
        s_err = 1'b0; s_ack = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0;
        settle();
        chk("drop_ack_m1_ack", m1_ack, 1);
        chk("drop_ack_s_cyc", s_cyc, 0);
        tick();
        s_ack = 1'b0;
        settle();
        chk("drop_idle_s_cyc", s_cyc, 0);

        // Simultaneous requests: m0 first, second tie depends on arbitration mode.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h1000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h2000;
        tick();
        s_ack = 1'b1;
        settle();
        chk("tie1_s_addr", s_addr, 32'h1000);
        chk("tie1_m0_ack", m0_ack, 1);
        chk("tie1_m1_ack", m1_ack, 0);
        tick();
        s_ack = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        settle();
        chk("tie2_idle_s_cyc", s_cyc, 0);
        tick();
        settle();
`ifdef WB_ARB_ROUND_ROBIN_EN
        tie2_addr = 32'h2000;
`else
        tie2_addr = 32'h1000;
`endif
        chk("tie2_s_addr", s_addr, tie2_addr);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // Strobe without cycle is ignored; cycle without strobe grants but keeps s_stb low.
        m0_stb = 1'b1;
        tick();
        settle();
        chk("stb_only_s_cyc", s_cyc, 0);
        chk("stb_only_s_stb", s_stb, 0);
        m0_cyc = 1'b1; m0_stb = 1'b0;
        tick();
        settle();
        chk("cyc_only_s_cyc", s_cyc, 1);
        chk("cyc_only_s_stb", s_stb, 0);

        // m0 burst with a strobe gap while m1 waits.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h200;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            if (b == 2) begin
                m0_stb = 1'b0; s_ack = 1'b0;
                settle();
                chk("gap_s_stb", s_stb, 0);
                chk("gap_s_cyc", s_cyc, 1);
                tick();
            end
            m0_stb = 1'b1; m0_addr = beat_addr[b]; m0_cti = beat_cti[b]; s_ack = 1'b1;
            settle();
            chk("burst_s_addr", s_addr, beat_addr[b]);
            chk("burst_s_cti", {29'd0, s_cti}, {29'd0, beat_cti[b]});
            chk("burst_m0_ack", m0_ack, 1);
            chk("burst_m1_ack", m1_ack, 0);
        end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_cti = CtiClassic; s_ack = 1'b0;
        settle();
        chk("burst_release_s_cyc", s_cyc, 0);
        tick();
        settle();
        chk("handover_idle_s_cyc", s_cyc, 0);
        tick();
        settle();
        chk("handover_s_cyc", s_cyc, 1);
        chk("handover_s_addr", s_addr, 32'h200);

        // Timeout: 4 stalled cycles, err on the 5th, grant kept; ack beats expiry.
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            chk("tmo_stall_m0_err", m0_err, 0);
        end
        tick();
        settle();
        chk("tmo_fire_m0_err", m0_err, 1);
        chk("tmo_fire_m1_err", m1_err, 0);
        tick();
        settle();
        chk("tmo_after_m0_err", m0_err, 0);
        chk("tmo_after_s_cyc", s_cyc, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk("tmo_restall_m0_err", m0_err, 0);
        end
        tick();
        s_ack = 1'b1;
        settle();
        chk("tmo_ack_wins_ack", m0_ack, 1);
        chk("tmo_ack_wins_err", m0_err, 0);
        tick();
        s_ack = 1'b0;
        settle();
        chk("tmo_cleared_m0_err", m0_err, 0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // Asynchronous reset in the middle of an m1 grant.
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h8000_0004;
        tick();
        settle();
        chk("pre_rst_s_cyc", s_cyc, 1);
        #1;
        rst = 1'b1; s_ack = 1'b1; s_err = 1'b1;
        #1;
        chk("async_rst_s_cyc", s_cyc, 0);
        chk("async_rst_s_stb", s_stb, 0);
        chk("async_rst_m1_ack", m1_ack, 0);
        chk("async_rst_m1_err", m1_err, 0);
        s_ack = 1'b0; s_err = 1'b0;
        rst = 1'b0;
        settle();
        chk("post_rst_idle_s_cyc", s_cyc, 0);
        tick();
        settle();
        chk("post_rst_regrant_s_cyc", s_cyc, 1);
        chk("post_rst_regrant_s_addr", s_addr, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
